// File: rtl/mem_wb_stage.sv
// Memory / writeback stage: issues data-memory and memory-mapped IO accesses
// for the instruction in execute, then produces the register-file writeback
// (also returned to execute as forwarding data) one cycle later.
module mem_wb_stage #(
    parameter int          DMEM_AWIDTH = 14,
    parameter logic [31:0] IO_BASE     = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   kill_i,
    input  logic [31:0]            alu_result_i,
    input  logic [31:0]            mem_write_i,
    input  logic [4:0]             wb_addr_i,
    input  logic [1:0]             control_wr_mux_i,
    input  logic [31:0]            pc_plus_i,
    input  logic [2:0]             funct3_i,
    input  logic                   reg_write_i,
    input  logic                   mem_read_i,
    input  logic                   mem_write_en_i,
    output logic [DMEM_AWIDTH-1:0] dmem_addr_o,
    output logic [3:0]             dmem_we_o,
    output logic [31:0]            dmem_din_o,
    input  logic [31:0]            dmem_dout_i,
    output logic [7:0]             uart_tx_data_o,
    output logic                   uart_tx_valid_o,
    input  logic                   uart_tx_ready_i,
    input  logic [7:0]             uart_rx_data_i,
    input  logic                   uart_rx_valid_i,
    output logic                   uart_rx_ready_o,
    output logic                   wb_en_o,
    output logic [4:0]             wb_addr_o,
    output logic [31:0]            wb_data_o,
    output logic [31:0]            forward_data_o
);

    localparam logic [31:0] OFF_STATUS = 32'h00;
    localparam logic [31:0] OFF_RXDATA = 32'h04;
    localparam logic [31:0] OFF_TXDATA = 32'h08;
    localparam logic [31:0] OFF_CYCLE  = 32'h10;
    localparam logic [31:0] OFF_INSTR  = 32'h14;
    localparam logic [31:0] OFF_CLEAR  = 32'h18;

    // Pick the addressed byte/halfword out of a word and extend it per funct3.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'b0, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'b0, h};
            default: load_extract = word;
        endcase
    endfunction

    logic        is_dmem, is_io, st_eff, ld_eff, io_clr;
    logic [31:0] io_off, io_rd_val, load_word, load_val;

    logic [4:0]  wb_addr_d,  wb_addr_q;
    logic [1:0]  wr_mux_d,   wr_mux_q;
    logic [31:0] pc_plus_d,  pc_plus_q;
    logic [31:0] alu_d,      alu_q;
    logic [2:0]  funct3_d,   funct3_q;
    logic [1:0]  off_d,      off_q;
    logic        sel_dmem_d, sel_dmem_q;
    logic        sel_io_d,   sel_io_q;
    logic [31:0] io_val_d,   io_val_q;
    logic        reg_write_d, reg_write_q;
    logic        valid_d,    valid_q;
    logic [31:0] cycle_cnt_d, cycle_cnt_q;
    logic [31:0] inst_cnt_d,  inst_cnt_q;

    // Cycle N: address decode, memory/UART strobes and IO read mux.
    always_comb begin
        is_dmem = (alu_result_i[31:28] == 4'b0001) || (alu_result_i[31:28] == 4'b0011);
        is_io   = (alu_result_i[31:28] == 4'b1000);
        io_off  = alu_result_i - IO_BASE;
        // Strobes are gated by rst so an instruction caught in reset has no effect.
        st_eff  = mem_write_en_i & ~kill_i & ~rst;
        ld_eff  = mem_read_i & ~kill_i & ~rst;

        dmem_addr_o = alu_result_i[DMEM_AWIDTH+1:2];
        dmem_we_o   = 4'b0000;
        if (st_eff && is_dmem) begin
            case (funct3_i)
                3'b000:  dmem_we_o = 4'b0001 << alu_result_i[1:0];
                3'b001:  dmem_we_o = 4'b0011 << {alu_result_i[1], 1'b0};
                3'b010:  dmem_we_o = 4'b1111;
                default: dmem_we_o = 4'b0000;
            endcase
        end
        // Replicating the store data means the byte enables alone select the lane.
        case (funct3_i[1:0])
            2'b00:   dmem_din_o = {4{mem_write_i[7:0]}};
            2'b01:   dmem_din_o = {2{mem_write_i[15:0]}};
            default: dmem_din_o = mem_write_i;
        endcase

        uart_tx_valid_o = st_eff & is_io & (io_off == OFF_TXDATA);
        uart_tx_data_o  = mem_write_i[7:0];
        uart_rx_ready_o = ld_eff & is_io & (io_off == OFF_RXDATA);
        io_clr          = st_eff & is_io & (io_off == OFF_CLEAR);

        io_rd_val = 32'b0;
        if (is_io) begin
            case (io_off)
                OFF_STATUS: io_rd_val = {30'b0, uart_rx_valid_i, uart_tx_ready_i};
                OFF_RXDATA: io_rd_val = {24'b0, uart_rx_data_i};
                OFF_CYCLE:  io_rd_val = cycle_cnt_q;
                OFF_INSTR:  io_rd_val = inst_cnt_q;
                default:    io_rd_val = 32'b0;
            endcase
        end
    end

    // Next-state for the stage register and the two counters.
    always_comb begin
        wb_addr_d   = wb_addr_i;
        wr_mux_d    = control_wr_mux_i;
        pc_plus_d   = pc_plus_i;
        alu_d       = alu_result_i;
        funct3_d    = funct3_i;
        off_d       = alu_result_i[1:0];
        sel_dmem_d  = is_dmem;
        sel_io_d    = is_io;
        io_val_d    = io_rd_val;
        reg_write_d = reg_write_i & ~kill_i;
        valid_d     = ~kill_i;
        // A clear store wins over the increment in the same cycle.
        cycle_cnt_d = io_clr ? 32'b0 : cycle_cnt_q + 32'd1;
        inst_cnt_d  = io_clr ? 32'b0 : inst_cnt_q + {31'b0, valid_q};
    end

    // Stage register and counters; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_addr_q   <= '0;
            wr_mux_q    <= '0;
            pc_plus_q   <= '0;
            alu_q       <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            sel_dmem_q  <= 1'b0;
            sel_io_q    <= 1'b0;
            io_val_q    <= '0;
            reg_write_q <= 1'b0;
            valid_q     <= 1'b0;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            wb_addr_q   <= wb_addr_d;
            wr_mux_q    <= wr_mux_d;
            pc_plus_q   <= pc_plus_d;
            alu_q       <= alu_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            sel_dmem_q  <= sel_dmem_d;
            sel_io_q    <= sel_io_d;
            io_val_q    <= io_val_d;
            reg_write_q <= reg_write_d;
            valid_q     <= valid_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    // Cycle N+1: load extraction and writeback mux.
    always_comb begin
        if (sel_dmem_q)    load_word = dmem_dout_i;
        else if (sel_io_q) load_word = io_val_q;
        else               load_word = 32'b0;
        load_val = load_extract(load_word, off_q, funct3_q);

        case (wr_mux_q)
            2'b00:   wb_data_o = alu_q;
            2'b01:   wb_data_o = load_val;
            2'b10:   wb_data_o = pc_plus_q;
            default: wb_data_o = 32'b0;
        endcase
        wb_en_o        = reg_write_q & (wb_addr_q != 5'd0);
        wb_addr_o      = wb_addr_q;
        forward_data_o = wb_data_o;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed test-plan sequence followed by random
// traffic, with a byte-level memory/counter reference model and a writeback
// scoreboard drained by an independent monitor.
module tb_mem_wb_stage;

    localparam int AW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, kill_i;
    logic [31:0]   alu_result_i, mem_write_i, pc_plus_i;
    logic [4:0]    wb_addr_i;
    logic [1:0]    control_wr_mux_i;
    logic [2:0]    funct3_i;
    logic          reg_write_i, mem_read_i, mem_write_en_i;
    logic [AW-1:0] dmem_addr_o;
    logic [3:0]    dmem_we_o;
    logic [31:0]   dmem_din_o, dmem_dout_i;
    logic [7:0]    uart_tx_data_o, uart_rx_data_i;
    logic          uart_tx_valid_o, uart_tx_ready_i, uart_rx_valid_i, uart_rx_ready_o;
    logic          wb_en_o;
    logic [4:0]    wb_addr_o;
    logic [31:0]   wb_data_o, forward_data_o;

    mem_wb_stage #(.DMEM_AWIDTH(AW), .IO_BASE(32'h8000_0000)) dut (
        .clk(clk), .rst(rst), .kill_i(kill_i),
        .alu_result_i(alu_result_i), .mem_write_i(mem_write_i), .wb_addr_i(wb_addr_i),
        .control_wr_mux_i(control_wr_mux_i), .pc_plus_i(pc_plus_i), .funct3_i(funct3_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_en_i(mem_write_en_i),
        .dmem_addr_o(dmem_addr_o), .dmem_we_o(dmem_we_o), .dmem_din_o(dmem_din_o),
        .dmem_dout_i(dmem_dout_i),
        .uart_tx_data_o(uart_tx_data_o), .uart_tx_valid_o(uart_tx_valid_o),
        .uart_tx_ready_i(uart_tx_ready_i), .uart_rx_data_i(uart_rx_data_i),
        .uart_rx_valid_i(uart_rx_valid_i), .uart_rx_ready_o(uart_rx_ready_o),
        .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .forward_data_o(forward_data_o)
    );

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          chk;
    } wb_exp_t;

    wb_exp_t     exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ram [int];   // environment data memory, word addressed
    logic [7:0]  mb  [int];   // reference model memory, byte addressed
    logic [31:0] m_cyc, m_inst;
    bit          m_pv, force_wrap;
    logic [2:0]  ld_f3  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] io_ld  [5] = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h0C};
    logic [31:0] io_st  [4] = '{32'h08, 32'h08, 32'h18, 32'h0C};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input logic [15:0] a);
        int k;
        k = int'({16'h0, a});
        return mb.exists(k) ? mb[k] : 8'h00;
    endfunction

    function automatic void mstore(input logic [15:0] a, input logic [7:0] b);
        mb[int'({16'h0, a})] = b;
    endfunction

    // Load as seen by software: little-endian bytes from the byte model.
    function automatic logic [31:0] model_load(input logic [15:0] a, input logic [2:0] f3);
        logic [15:0] ha, wa;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        ha = {a[15:1], 1'b0};
        wa = {a[15:2], 2'b00};
        b  = mbyte(a);
        h  = {mbyte(ha + 16'd1), mbyte(ha)};
        w  = {mbyte(wa + 16'd3), mbyte(wa + 16'd2), mbyte(wa + 16'd1), mbyte(wa)};
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // One clock: environment memory responds, reference counters advance.
    task automatic step(input bit clr, input bit vld, input bit in_rst);
        logic [AW-1:0] a;
        logic [3:0]    we;
        logic [31:0]   din, w;
        int            k;
        a   = dmem_addr_o;
        we  = dmem_we_o;
        din = dmem_din_o;
        @(posedge clk);
        k = int'(a);
        w = ram.exists(k) ? ram[k] : 32'h0;
        dmem_dout_i = w;
        for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = din[8*i +: 8];
        if (we != 4'b0) ram[k] = w;
        if (in_rst) begin
            m_cyc = 0; m_inst = 0; m_pv = 0;
        end else begin
            if (force_wrap) m_cyc = 32'hFFFF_FFFF;
            else if (clr)   m_cyc = 32'h0;
            else            m_cyc = m_cyc + 32'd1;
            if (clr) m_inst = 32'h0;
            else     m_inst = m_inst + 32'(m_pv);
            m_pv = vld;
        end
        @(negedge clk);
    endtask

    task automatic issue(input bit kill, input logic [31:0] alu, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic [1:0] mux, input logic [31:0] pc,
                         input logic [2:0] f3, input bit rw, input bit mr, input bit mw);
        logic [3:0]  exp_we;
        logic [31:0] exp_din, ld_val, exp_data, off;
        logic [15:0] a, ha;
        bit          dm, io, st, ld, clr, txv;
        wb_exp_t     e;
        rst = 1'b0; kill_i = kill; alu_result_i = alu; mem_write_i = wdata;
        wb_addr_i = rd; control_wr_mux_i = mux; pc_plus_i = pc; funct3_i = f3;
        reg_write_i = rw; mem_read_i = mr; mem_write_en_i = mw;
        #1;
        a   = alu[15:0];
        ha  = {a[15:1], 1'b0};
        dm  = (alu[31:28] == 4'h1) || (alu[31:28] == 4'h3);
        io  = (alu[31:28] == 4'h8);
        off = alu - 32'h8000_0000;
        st  = mw && !kill;
        ld  = mr && !kill;
        exp_we  = 4'b0;
        exp_din = wdata;
        if (st && dm) begin
            case (f3)
                3'd0: begin exp_we[a[1:0]] = 1'b1; exp_din = {4{wdata[7:0]}}; end
                3'd1: begin
                    exp_we[ha[1:0]] = 1'b1; exp_we[ha[1:0] + 2'd1] = 1'b1;
                    exp_din = {2{wdata[15:0]}};
                end
                3'd2: exp_we = 4'hF;
                default: exp_we = 4'b0;
            endcase
        end
        chk("dmem_addr", 32'(dmem_addr_o), 32'(alu[AW+1:2]));
        chk("dmem_we", 32'(dmem_we_o), 32'(exp_we));
        if (exp_we != 4'b0) chk("dmem_din", dmem_din_o, exp_din);
        txv = st && io && (off == 32'h08);
        chk("uart_tx_valid", 32'(uart_tx_valid_o), 32'(txv));
        if (txv) chk("uart_tx_data", 32'(uart_tx_data_o), 32'(wdata[7:0]));
        chk("uart_rx_ready", 32'(uart_rx_ready_o), 32'(ld && io && (off == 32'h04)));
        clr = st && io && (off == 32'h18);

        ld_val = 32'h0;
        if (dm) ld_val = model_load(a, f3);
        else if (io) begin
            case (off)
                32'h00:  ld_val = {30'h0, uart_rx_valid_i, uart_tx_ready_i};
                32'h04:  ld_val = {24'h0, uart_rx_data_i};
                32'h10:  ld_val = m_cyc;
                32'h14:  ld_val = m_inst;
                default: ld_val = 32'h0;
            endcase
        end
        case (mux)
            2'd0:    exp_data = alu;
            2'd1:    exp_data = ld_val;
            2'd2:    exp_data = pc;
            default: exp_data = 32'h0;
        endcase
        e.en = rw && !kill && (rd != 5'd0);
        e.addr = rd; e.data = exp_data; e.chk = !kill;
        exp_q.push_back(e);

        if (st && dm) begin
            case (f3)
                3'd0: mstore(a, wdata[7:0]);
                3'd1: begin mstore(ha, wdata[7:0]); mstore(ha + 16'd1, wdata[15:8]); end
                3'd2: for (int i = 0; i < 4; i++)
                          mstore({a[15:2], 2'b00} + 16'(i), wdata[8*i +: 8]);
                default: ;
            endcase
        end
        step(clr, !kill, 1'b0);
    endtask

    task automatic reset_cycle(input logic [31:0] alu, input logic [31:0] wdata,
                               input bit mw, input bit mr);
        wb_exp_t e;
        rst = 1'b1; kill_i = 1'b0; alu_result_i = alu; mem_write_i = wdata;
        wb_addr_i = 5'd7; control_wr_mux_i = 2'd0; pc_plus_i = 32'h44; funct3_i = 3'd2;
        reg_write_i = 1'b1; mem_read_i = mr; mem_write_en_i = mw;
        #1;
        chk("rst_dmem_we", 32'(dmem_we_o), 32'h0);
        chk("rst_tx_valid", 32'(uart_tx_valid_o), 32'h0);
        chk("rst_rx_ready", 32'(uart_rx_ready_o), 32'h0);
        e.en = 1'b0; e.addr = 5'd0; e.data = 32'h0; e.chk = 1'b1;
        exp_q.push_back(e);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic ld(input logic [31:0] alu, input logic [4:0] rd, input logic [2:0] f3);
        issue(1'b0, alu, 32'h0, rd, 2'd1, 32'h0, f3, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic st(input logic [31:0] alu, input logic [31:0] d, input logic [2:0] f3);
        issue(1'b0, alu, d, 5'd0, 2'd0, 32'h0, f3, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic nop();
        issue(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: after every active edge, compare writeback against the scoreboard.
    always @(posedge clk) begin : monitor
        wb_exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_en", 32'(wb_en_o), 32'(e.en));
            if (e.chk) begin
                chk("wb_addr", 32'(wb_addr_o), 32'(e.addr));
                chk("wb_data", wb_data_o, e.data);
                chk("forward_data", forward_data_o, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; kill_i = 1'b1; alu_result_i = 0; mem_write_i = 0; wb_addr_i = 0;
        control_wr_mux_i = 0; pc_plus_i = 0; funct3_i = 0; reg_write_i = 0;
        mem_read_i = 0; mem_write_en_i = 0; dmem_dout_i = 0;
        uart_tx_ready_i = 0; uart_rx_data_i = 0; uart_rx_valid_i = 0;
        m_cyc = 0; m_inst = 0; m_pv = 0; force_wrap = 0;
        @(negedge clk);
        reset_cycle(32'h0, 32'h0, 1'b0, 1'b0);
        reset_cycle(32'h0, 32'h0, 1'b0, 1'b0);

        repeat (10) nop();
        ld(32'h8000_0010, 5'd10, 3'd2);

        st(32'h1000_0008, 32'hDEAD_BEEF, 3'd2);
        ld(32'h1000_000B, 5'd1, 3'd0);
        ld(32'h1000_000B, 5'd2, 3'd4);
        ld(32'h1000_000A, 5'd3, 3'd1);
        ld(32'h1000_000A, 5'd4, 3'd5);
        ld(32'h1000_0008, 5'd5, 3'd2);
        ld(32'h1000_0009, 5'd6, 3'd0);
        st(32'h1000_0001, 32'h0000_0012, 3'd0);
        st(32'h1000_0002, 32'h0000_ABCD, 3'd1);
        ld(32'h1000_0000, 5'd7, 3'd2);
        ld(32'h3000_0000, 5'd8, 3'd2);

        uart_rx_valid_i = 1'b1; uart_rx_data_i = 8'h41; uart_tx_ready_i = 1'b1;
        ld(32'h8000_0000, 5'd9, 3'd2);
        ld(32'h8000_0004, 5'd11, 3'd2);
        st(32'h8000_0008, 32'h0000_005A, 3'd2);
        uart_tx_ready_i = 1'b0;
        ld(32'h8000_0000, 5'd9, 3'd2);

        ld(32'h8000_0014, 5'd12, 3'd2);
        st(32'h8000_0018, 32'h1234_5678, 3'd2);
        ld(32'h8000_0010, 5'd13, 3'd2);
        ld(32'h8000_0010, 5'd13, 3'd2);
        ld(32'h8000_0014, 5'd14, 3'd2);

        force dut.cycle_cnt_d = 32'hFFFF_FFFF;
        force_wrap = 1'b1;
        nop();
        force_wrap = 1'b0;
        release dut.cycle_cnt_d;
        ld(32'h8000_0010, 5'd15, 3'd2);
        ld(32'h8000_0010, 5'd15, 3'd2);

        issue(1'b0, 32'h55, 32'h0, 5'd1, 2'd2, 32'h104, 3'd0, 1'b1, 1'b0, 1'b0);
        issue(1'b0, 32'h55, 32'h0, 5'd0, 2'd2, 32'h104, 3'd0, 1'b1, 1'b0, 1'b0);
        issue(1'b0, 32'h55, 32'h0, 5'd2, 2'd3, 32'h104, 3'd0, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 5'd3, 2'd0, 32'h0, 3'd2, 1'b1, 1'b0, 1'b1);
        ld(32'h1000_0010, 5'd16, 3'd2);
        issue(1'b1, 32'h8000_0018, 32'h0, 5'd0, 2'd0, 32'h0, 3'd2, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 32'h8000_0008, 32'h77, 5'd0, 2'd0, 32'h0, 3'd2, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 32'h8000_0004, 32'h0, 5'd4, 2'd1, 32'h0, 3'd2, 1'b1, 1'b1, 1'b0);
        ld(32'h8000_0010, 5'd17, 3'd2);

        reset_cycle(32'h8000_0008, 32'h5A, 1'b1, 1'b0);
        reset_cycle(32'h8000_0004, 32'h0, 1'b0, 1'b1);
        ld(32'h8000_0010, 5'd18, 3'd2);
        ld(32'h8000_0014, 5'd19, 3'd2);

        for (int n = 0; n < 300; n++) begin
            int          op;
            bit          kill;
            logic [31:0] d, pc, alu;
            logic [4:0]  rd;
            uart_rx_valid_i = 1'($urandom_range(0, 1));
            uart_rx_data_i  = 8'($urandom);
            uart_tx_ready_i = 1'($urandom_range(0, 1));
            kill = ($urandom_range(0, 7) == 0);
            rd   = 5'($urandom);
            d    = $urandom;
            pc   = $urandom;
            op   = int'($urandom_range(0, 11));
            case (op)
                0: issue(kill, $urandom, d, rd, 2'd0, pc, 3'($urandom), 1'b1, 1'b0, 1'b0);
                1: issue(kill, $urandom, d, rd, 2'd2, pc, 3'd0, 1'b1, 1'b0, 1'b0);
                2: issue(kill, $urandom, d, rd, 2'd3, pc, 3'd0, 1'b1, 1'b0, 1'b0);
                3, 4, 5: begin
                    alu = {($urandom_range(0, 1) == 1) ? 4'h1 : 4'h3, 22'h0, 6'($urandom)};
                    issue(kill, alu, d, rd, 2'd1, pc, ld_f3[$urandom_range(0, 4)], 1'b1, 1'b1, 1'b0);
                end
                6, 7: begin
                    alu = {($urandom_range(0, 1) == 1) ? 4'h1 : 4'h3, 22'h0, 6'($urandom)};
                    issue(kill, alu, d, rd, 2'd0, pc, 3'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b1);
                end
                8: issue(kill, 32'h8000_0000 + io_ld[$urandom_range(0, 4)], d, rd, 2'd1, pc,
                         3'd2, 1'b1, 1'b1, 1'b0);
                9: issue(kill, 32'h8000_0000 + io_st[$urandom_range(0, 3)], d, rd, 2'd0, pc,
                         3'd2, 1'b0, 1'b0, 1'b1);
                10: issue(kill, {4'h5, 28'($urandom)}, d, rd, 2'd1, pc, ld_f3[$urandom_range(0, 4)],
                          1'b1, 1'b1, 1'b0);
                default: issue(kill, {4'h2, 28'($urandom)}, d, rd, 2'd0, pc, 3'($urandom_range(0, 2)),
                               1'b0, 1'b0, 1'b1);
            endcase
            if ($urandom_range(0, 63) == 0)
                reset_cycle($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) issue(1'b1, 32'h0, 32'h0, 5'd0, 2'd0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
